// File: rtl/dmem_store_buffer.sv
// Committed-store buffer in front of a single-port data memory.
// Stores are queued in a circular FIFO and drained to dmem whenever no load
// is using the port. Loads are checked against the queued stores, and the
// youngest matching store is forwarded in place of the stale dmem read.
module dmem_store_buffer #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset_x,
  input  logic                        st_valid,
  input  logic [ADDR_LEN-1:0]         st_addr,
  input  logic [DATA_LEN-1:0]         st_data,
  output logic                        st_ready,
  input  logic                        ld_valid,
  input  logic [ADDR_LEN-1:0]         ld_addr,
  output logic [DATA_LEN-1:0]         ld_data,
  output logic                        ld_data_valid,
  output logic [ADDR_LEN-1:0]         mem_addr,
  output logic [DATA_LEN-1:0]         mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_LEN-1:0]         mem_rdata,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_LEN-1:0] addr_mem [DEPTH];
  logic [DATA_LEN-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    cnt;
  logic                full;
  logic                push;
  logic                pop;
  logic [PTR_W-1:0]    idx;
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;
  logic                fwd_hit_p1;
  logic [DATA_LEN-1:0] fwd_data_p1;
  logic                vld_p1;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign st_ready = !full;
  assign count    = cnt;
  // A load owns the port, so draining only happens on load-free cycles.
  assign push     = st_valid && !full;
  assign pop      = !ld_valid && !empty;

  // Single dmem port arbitration: load first, then drain head, else idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_addr  = addr_mem[head];
      mem_wdata = data_mem[head];
      mem_we    = 1'b1;
    end
  end

  // Forwarding search walks oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (addr_mem[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  // Entry payload storage; no reset, occupancy is tracked by the valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_data;
    end
  end

  // FIFO control: pointers, valid bits and occupancy count.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---- stage p0 -> p1: load result registered alongside dmem read latency
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      vld_p1      <= 1'b0;
      fwd_hit_p1  <= 1'b0;
      fwd_data_p1 <= '0;
    end else begin
      vld_p1 <= ld_valid;
      if (ld_valid) begin
        fwd_hit_p1  <= fwd_hit;
        fwd_data_p1 <= fwd_data;
      end
    end
  end

  assign ld_data_valid = vld_p1;
  assign ld_data       = !vld_p1    ? '0 :
                         fwd_hit_p1 ? fwd_data_p1 : mem_rdata;

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, word address width, matching the dmem addr port.
REQ-002 SHALL have parameter DATA_LEN, default 32, data word width, matching the dmem data ports.
REQ-003 SHALL have parameter DEPTH, default 4, number of store entries; a power of two, 2..16.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_x  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port st_valid  in  1  committed-store push request.
REQ-007 SHALL have port st_addr  in  ADDR_LEN  store word address.
REQ-008 SHALL have port st_data  in  DATA_LEN  store data.
REQ-009 SHALL have port st_ready  out  1  buffer can accept a push; equals !full.
REQ-010 SHALL have port ld_valid  in  1  load request this cycle.
REQ-011 SHALL have port ld_addr  in  ADDR_LEN  load word address.
REQ-012 SHALL have port ld_data  out  DATA_LEN  load result, valid one cycle after the request.
REQ-013 SHALL have port ld_data_valid  out  1  ld_data is valid this cycle.
REQ-014 SHALL have port mem_addr  out  ADDR_LEN  to the dmem addr port.
REQ-015 SHALL have port mem_wdata  out  DATA_LEN  to the dmem wdata port.
REQ-016 SHALL have port mem_we  out  1  to the dmem we port.
REQ-017 SHALL have port mem_rdata  in  DATA_LEN  from dmem rdata; one-cycle read latency.
REQ-018 SHALL have port count  out  log2(DEPTH)+1  number of occupied entries.
REQ-019 SHALL have port empty  out  1  count==0.

Function
REQ-020 SHALL store entries in a circular FIFO with head/tail pointers that wrap modulo DEPTH, plus a valid bit per entry.
REQ-021 SHALL accept a push only when st_valid && st_ready, writing {st_addr, st_data} at tail and advancing tail.
REQ-022 SHALL ignore st_valid while full; the entry is not written and count does not change.
REQ-023 SHALL drive the single dmem port combinationally with priority load > drain:
- ld_valid=1: mem_addr=ld_addr, mem_we=0.
- else !empty: mem_addr=head.addr, mem_wdata=head.data, mem_we=1, pop head at the edge.
- else: mem_we=0, mem_addr=0.
REQ-024 SHALL keep mem_we=0 whenever ld_valid=1, so a load stalls draining indefinitely.
REQ-025 SHALL update count by +1 on push only, -1 on pop only, and 0 on push and pop in the same cycle.
REQ-026 SHALL make a push from an empty buffer drainable no earlier than the next cycle; there is no same-cycle push-to-dmem bypass.
REQ-027 SHALL compare ld_addr against all valid entries held before the edge; a push in the same cycle is not visible to that load.
REQ-028 SHALL select the youngest matching entry (closest to tail) when several entries match.
REQ-029 SHALL register fwd_hit and fwd_data on a load, and set ld_data_valid = ld_valid delayed one cycle.
REQ-030 SHALL drive ld_data = fwd_hit_q ? fwd_data_q : mem_rdata, and 0 when ld_data_valid=0.
REQ-031 SHALL leave no stale-data hazard for a load issued the cycle after a drain of the same address, because dmem commits the write at the draining edge.
REQ-032 SHALL allow back-to-back loads every cycle, with each result one cycle after its request.

Reset
REQ-033 SHALL on reset_x=0 immediately clear all valid bits, head, tail, count, fwd_hit_q, fwd_data_q and ld_data_valid; empty=1, st_ready=1.
REQ-034 SHALL silently discard pending stores when reset occurs mid-operation; no further mem_we until a new push.
REQ-035 SHALL use no reset on the entry addr/data storage.

Verification
REQ-036 SHALL cover: push (0x10,0xAAAA), no load -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA; then empty=1.
REQ-037 SHALL cover: push (0x20,0x1111) then (0x20,0x2222) with ld_valid held; load 0x20 -> ld_data=0x2222 one cycle later, and mem_we=0 throughout.
REQ-038 SHALL cover: 4 pushes with ld_valid held -> count=4, st_ready=0; a 5th push is ignored; release the load -> 4 drains in FIFO order on consecutive cycles.
REQ-039 SHALL cover: push 0x30 and load 0x30 in the same cycle -> ld_data=mem_rdata (no forward); the entry drains afterwards.
REQ-040 SHALL cover: wrap-around, i.e. 10 push/drain pairs -> pointers wrap and data order is preserved.
REQ-041 SHALL cover: reset_x pulsed low with count=3 -> count=0, empty=1, ld_data_valid=0 asynchronously, and mem_we stays 0.
